tdc_meas_ctrl: RTL and testbench

Measurement sequencer for the tapped-delay-line TDC. On each request it resets the delay line, launches the start edge and fires a capture strobe after a programmable number of clk cycles. It then latches the N_DELAY-bit thermometer code, encodes it to a tap count with a bubble flag, and streams a result frame byte by byte over an 8-bit valid/ready port. It sits between the host-side pin interface and the delay-line instance.

---
 rtl/tdc_pkg.sv | 35 +++
 rtl/tdc_therm_encoder.sv | 32 +++
 rtl/tdc_meas_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_tdc_meas_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tdc_pkg.sv
// Shared types and sizing helpers for the TDC measurement sequencer.
// Sizes derive from the delay-line length N_DELAY.
package tdc_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT,
      CAPTURE,
      LATCH,
      READOUT
   } state_e;

   localparam int N_DELAY_DEF = 32;
   localparam int NBYTES      = N_DELAY_DEF / 8;
   localparam int FRAME_LEN   = NBYTES + 1;
   localparam int CNT_W       = $clog2(N_DELAY_DEF + 1);

   function automatic int f_nbytes(input int n_delay);
      return n_delay / 8;
   endfunction

   function automatic int f_frame_len(input int n_delay);
      return n_delay / 8 + 1;
   endfunction

   function automatic int f_cnt_w(input int n_delay);
      return $clog2(n_delay + 1);
   endfunction

   function automatic int f_idx_w(input int n_delay);
      return $clog2(n_delay / 8 + 1);
   endfunction

endpackage

// File: rtl/tdc_therm_encoder.sv
// Thermometer-to-count encoder: number of contiguous ones from bit 0,
// plus a flag for any stray one above the first zero.
module tdc_therm_encoder
   import tdc_pkg::*;
#(
   parameter int N_DELAY = 32,
   localparam int CW = f_cnt_w(N_DELAY)
) (
   input  logic [N_DELAY-1:0] code,
   output logic [CW-1:0]      count,
   output logic               bubble
);

   logic found;

   always_comb begin
      found  = 1'b0;
      count  = CW'(N_DELAY);
      bubble = 1'b0;
      for (int i = 0; i < N_DELAY; i++) begin
         if (found) begin
            if (code[i]) begin
               bubble = 1'b1;
            end
         end else if (!code[i]) begin
            found = 1'b1;
            count = CW'(i);
         end
      end
   end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer: settle, launch, capture, encode, then stream
// a count byte followed by the raw code bytes over valid/ready.
module tdc_meas_ctrl
   import tdc_pkg::*;
#(
   parameter int N_DELAY       = 32,
   parameter int SETTLE_CYCLES = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               meas_req,
   input  logic [7:0]         meas_delay,
   output logic               busy,
   output logic               tdc_rst_n,
   output logic               tdc_start,
   output logic               tdc_capture,
   input  logic [N_DELAY-1:0] code_in,
   output logic [7:0]         out_data,
   output logic               out_valid,
   input  logic               out_ready,
   output logic               out_last,
   output logic               err_bubble
);

   localparam int BYTES       = f_nbytes(N_DELAY);
   localparam int FRAME_BYTES = f_frame_len(N_DELAY);
   localparam int CW          = f_cnt_w(N_DELAY);
   localparam int IW          = f_idx_w(N_DELAY);
   localparam int NSLOT       = 1 << IW;

   localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST    = IW'(FRAME_BYTES - 1);

   state_e             state_q, state_d;
   logic [7:0]         cnt_q, cnt_d;
   logic [7:0]         dly_q, dly_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic [N_DELAY-1:0] code_q, code_d;
   logic [CW-1:0]      count_q, count_d;
   logic               err_q, err_d;
   logic               busy_q, busy_d;
   logic               tdc_rst_n_q, tdc_rst_n_d;
   logic               start_q, start_d;
   logic               capture_q, capture_d;
   logic               valid_q, valid_d;

   logic [CW-1:0]      enc_count;
   logic               enc_bubble;
   logic [7:0]         frame_bytes [NSLOT];

   tdc_therm_encoder #(
      .N_DELAY (N_DELAY)
   ) u_enc (
      .code   (code_in),
      .count  (enc_count),
      .bubble (enc_bubble)
   );

   // Frame slot 0 is the tap count; slots past the frame are tied off so
   // the full index range is addressable.
   genvar gi;
   generate
      for (gi = 0; gi < NSLOT; gi++) begin : g_slot
         if (gi == 0) begin : g_count
            assign frame_bytes[gi] = 8'(count_q);
         end else if (gi <= BYTES) begin : g_code
            assign frame_bytes[gi] = code_q[(gi-1)*8 +: 8];
         end else begin : g_pad
            assign frame_bytes[gi] = 8'h00;
         end
      end
   endgenerate

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dly_d   = dly_q;
      idx_d   = idx_q;
      code_d  = code_q;
      count_d = count_q;
      err_d   = err_q;

      case (state_q)
         IDLE: begin
            if (meas_req) begin
               dly_d   = meas_delay;
               err_d   = 1'b0;
               cnt_d   = 8'd0;
               state_d = ARM;
            end
         end
         ARM: begin
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = 8'd0;
               state_d = WAIT;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         WAIT: begin
            if (cnt_q == dly_q) begin
               cnt_d   = 8'd0;
               state_d = CAPTURE;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         CAPTURE: begin
            state_d = LATCH;
         end
         LATCH: begin
            code_d  = code_in;
            count_d = enc_count;
            err_d   = enc_bubble;
            idx_d   = '0;
            state_d = READOUT;
         end
         READOUT: begin
            if (out_ready) begin
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = IDLE;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Outputs are decoded from the next state so they register in step
      // with the state they belong to.
      busy_d      = (state_d != IDLE);
      tdc_rst_n_d = (state_d == WAIT) || (state_d == CAPTURE) || (state_d == LATCH);
      start_d     = (state_d == WAIT) || (state_d == CAPTURE);
      capture_d   = (state_d == CAPTURE);
      valid_d     = (state_d == READOUT);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= 8'd0;
         dly_q       <= 8'd0;
         idx_q       <= '0;
         code_q      <= '0;
         count_q     <= '0;
         err_q       <= 1'b0;
         busy_q      <= 1'b0;
         tdc_rst_n_q <= 1'b0;
         start_q     <= 1'b0;
         capture_q   <= 1'b0;
         valid_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dly_q       <= dly_d;
         idx_q       <= idx_d;
         code_q      <= code_d;
         count_q     <= count_d;
         err_q       <= err_d;
         busy_q      <= busy_d;
         tdc_rst_n_q <= tdc_rst_n_d;
         start_q     <= start_d;
         capture_q   <= capture_d;
         valid_q     <= valid_d;
      end
   end

   assign busy        = busy_q;
   assign tdc_rst_n   = tdc_rst_n_q;
   assign tdc_start   = start_q;
   assign tdc_capture = capture_q;
   assign out_valid   = valid_q;
   assign err_bubble  = err_q;
   assign out_data    = valid_q ? frame_bytes[idx_q] : 8'h00;
   assign out_last    = valid_q && (idx_q == IDX_LAST);

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl: table of frames plus hand-written
// reset and backpressure sequences.
module tb_tdc_meas_ctrl;

   localparam int N_DELAY = 32;
   localparam int SETTLE  = 4;

   logic               clk;
   logic               rst_n;
   logic               meas_req;
   logic [7:0]         meas_delay;
   logic               busy;
   logic               tdc_rst_n;
   logic               tdc_start;
   logic               tdc_capture;
   logic [N_DELAY-1:0] code_in;
   logic [7:0]         out_data;
   logic               out_valid;
   logic               out_ready;
   logic               out_last;
   logic               err_bubble;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [31:0] code;
      logic [7:0]  dly;
      logic [7:0]  exp_b0;
      logic        exp_bub;
      int          mode;
   } vec_t;

   vec_t vecs [9];

   tdc_meas_ctrl #(
      .N_DELAY       (N_DELAY),
      .SETTLE_CYCLES (SETTLE)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .meas_req    (meas_req),
      .meas_delay  (meas_delay),
      .busy        (busy),
      .tdc_rst_n   (tdc_rst_n),
      .tdc_start   (tdc_start),
      .tdc_capture (tdc_capture),
      .code_in     (code_in),
      .out_data    (out_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_last    (out_last),
      .err_bubble  (err_bubble)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " busy"},        64'(busy),        64'd0);
      check({tag, " tdc_rst_n"},   64'(tdc_rst_n),   64'd0);
      check({tag, " tdc_start"},   64'(tdc_start),   64'd0);
      check({tag, " tdc_capture"}, 64'(tdc_capture), 64'd0);
      check({tag, " out_valid"},   64'(out_valid),   64'd0);
      check({tag, " out_last"},    64'(out_last),    64'd0);
      check({tag, " out_data"},    64'(out_data),    64'd0);
      check({tag, " err_bubble"},  64'(err_bubble),  64'd0);
   endtask

   // mode 0: ready always high; 1: stall on byte 2 then toggle;
   // 2: extra meas_req pulses in WAIT and READOUT.
   task automatic run_frame(input logic [31:0] code, input logic [7:0] dly, input int mode,
                            input logic [7:0] exp_b0, input logic exp_bub, input string tag);
      logic [7:0] got [$];
      logic       lastf [$];
      int         cap_cycle = -1;
      int         cap_cnt = 0;
      int         val_cycle = -1;
      int         cyc = 1;
      int         stall = 0;
      int         exp_cap;
      int         busy_seen = 0;
      logic [7:0] prev_data = 8'h00;
      logic       prev_last = 1'b0;
      logic       prev_stalled = 1'b0;
      logic [7:0] exp_byte;
      bit         done = 0;

      code_in    = code;
      meas_delay = dly;
      out_ready  = 1'b1;
      @(posedge clk); #1;
      meas_req = 1'b1;
      @(posedge clk); #1;
      meas_req   = 1'b0;
      meas_delay = ~dly;
      while (!done && cyc < 700) begin
         if (tdc_capture) begin
            cap_cnt++;
            if (cap_cycle < 0) cap_cycle = cyc;
         end
         if (out_valid && val_cycle < 0) val_cycle = cyc;
         if (prev_stalled) begin
            check({tag, " stall data"},  64'(out_data),  64'(prev_data));
            check({tag, " stall last"},  64'(out_last),  64'(prev_last));
            check({tag, " stall valid"}, 64'(out_valid), 64'd1);
         end
         if (mode == 1 && out_valid) begin
            if (got.size() == 2 && stall < 5) begin
               out_ready = 1'b0;
               stall++;
            end else if (stall >= 5) begin
               out_ready = ~out_ready;
            end else begin
               out_ready = 1'b1;
            end
         end
         meas_req = (mode == 2) && (cyc == SETTLE + 1 || cyc == val_cycle);
         prev_stalled = out_valid && !out_ready;
         prev_data    = out_data;
         prev_last    = out_last;
         if (out_valid && out_ready) begin
            got.push_back(out_data);
            lastf.push_back(out_last);
            if (out_last || got.size() > 8) done = 1;
         end
         @(posedge clk); #1;
         cyc++;
      end
      meas_req  = 1'b0;
      out_ready = 1'b1;

      exp_cap = SETTLE + int'(dly) + 2;
      check({tag, " timeout"},      64'(done),        64'd1);
      check({tag, " capture cyc"},  64'(cap_cycle),   64'(exp_cap));
      check({tag, " capture cnt"},  64'(cap_cnt),     64'd1);
      check({tag, " valid cyc"},    64'(val_cycle),   64'(exp_cap + 2));
      check({tag, " frame len"},    64'(got.size()),  64'd5);
      for (int i = 0; i < got.size() && i < 5; i++) begin
         exp_byte = (i == 0) ? exp_b0 : code[(i-1)*8 +: 8];
         check($sformatf("%s byte%0d", tag, i), 64'(got[i]),   64'(exp_byte));
         check($sformatf("%s last%0d", tag, i), 64'(lastf[i]), 64'(i == 4));
      end
      check({tag, " busy end"},   64'(busy),       64'd0);
      check({tag, " valid end"},  64'(out_valid),  64'd0);
      check({tag, " bubble"},     64'(err_bubble), 64'(exp_bub));
      if (mode == 2) begin
         for (int i = 0; i < 4; i++) begin
            if (busy) busy_seen++;
            @(posedge clk); #1;
         end
         check({tag, " no requeue"}, 64'(busy_seen), 64'd0);
      end
      $display("frame %s: code=%08h dly=%0d bytes=%0d capture@%0d valid@%0d bubble=%0b",
               tag, code, dly, got.size(), cap_cycle, val_cycle, err_bubble);
   endtask

   // Start a measurement and pull reset for one edge either in WAIT
   // (at_byte < 0) or while frame byte at_byte is presented.
   task automatic reset_mid(input int at_byte, input string tag);
      int cyc = 1;
      int nacc = 0;
      bit hit = 0;

      code_in    = 32'h0000_0F0F;
      meas_delay = 8'd3;
      out_ready  = 1'b1;
      @(posedge clk); #1;
      meas_req = 1'b1;
      @(posedge clk); #1;
      meas_req = 1'b0;
      while (!hit && cyc < 100) begin
         if (at_byte < 0) begin
            hit = (cyc == SETTLE + 2);
         end else if (out_valid && nacc == at_byte) begin
            hit = 1;
         end else if (out_valid && out_ready) begin
            nacc++;
         end
         if (hit) begin
            check({tag, " busy before"}, 64'(busy), 64'd1);
            rst_n = 1'b0;
         end
         @(posedge clk); #1;
         cyc++;
      end
      rst_n = 1'b1;
      check({tag, " reached"}, 64'(hit), 64'd1);
      check_reset_outputs(tag);
      @(posedge clk); #1;
      check({tag, " idle hold"}, 64'(busy), 64'd0);
      $display("reset %s: at_byte=%0d cycle=%0d", tag, at_byte, cyc);
   endtask

   initial begin
      vecs[0] = '{32'h0000_00FF, 8'd2,   8'h08, 1'b0, 0};
      vecs[1] = '{32'h0000_0F0F, 8'd1,   8'h04, 1'b1, 0};
      vecs[2] = '{32'hFFFF_FFFF, 8'd3,   8'h20, 1'b0, 0};
      vecs[3] = '{32'h0000_0000, 8'd0,   8'h00, 1'b0, 0};
      vecs[4] = '{32'h7FFF_FFFF, 8'd255, 8'h1F, 1'b0, 0};
      vecs[5] = '{32'h8000_0000, 8'd2,   8'h00, 1'b1, 0};
      vecs[6] = '{32'hA5C3_3C0F, 8'd2,   8'h04, 1'b1, 1};
      vecs[7] = '{32'h0000_0007, 8'd4,   8'h03, 1'b0, 2};
      vecs[8] = '{32'h0000_0001, 8'd0,   8'h01, 1'b0, 0};

      rst_n      = 1'b0;
      meas_req   = 1'b0;
      meas_delay = 8'd0;
      code_in    = '0;
      out_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(posedge clk); #1;

      for (int v = 0; v < 9; v++) begin
         run_frame(vecs[v].code, vecs[v].dly, vecs[v].mode,
                   vecs[v].exp_b0, vecs[v].exp_bub, $sformatf("vec%0d", v));
      end

      reset_mid(-1, "rst_wait");
      run_frame(32'h0000_00FF, 8'd2, 0, 8'h08, 1'b0, "after_rst_wait");
      reset_mid(3, "rst_readout");
      run_frame(32'h0000_3FFF, 8'd1, 0, 8'h0E, 1'b0, "after_rst_readout");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
